// File: rtl/genclk_if.sv
// Load/output bundle of the serializer pattern generator: step strobe in,
// eight-sample word and its valid flag out.
interface genclk_if #(
  parameter int BW = 32
);
  logic          i_stb;
  logic [BW-1:0] i_delay;
  logic [7:0]    o_word;
  logic          o_stb;

  modport master (output i_stb, output i_delay, input o_word, input o_stb);
  modport slave  (input i_stb, input i_delay, output o_word, output o_stb);
endinterface

// File: rtl/genclk.sv
// Phase-accumulator clock pattern generator: emits eight serial samples per
// i_clk cycle for an 8:1 serializer, one MSB tap per sub-bit phase.
module genclk #(
  parameter int BW = 32
) (
  input  logic     i_clk,
  input  logic     i_reset,
  genclk_if.slave  bus
);

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    WARM2 = 2'd2,
    RUN   = 2'd3
  } warm_t;

  logic [BW-1:0] step_r;
  logic [BW-1:0] mult_r [8];
  logic [BW-1:0] mult_s [8];
  logic [BW-1:0] ctr_r;
  logic [7:0]    word_r;
  logic [7:0]    word_s;
  logic          stb_r;
  logic          stb_s;
  warm_t         st_r;
  warm_t         st_s;

  // Multiples of the current step, built as an adder chain so all eight land on one edge
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      mult_s[k] = '0;
    end
    mult_s[0] = step_r;
    for (int k = 1; k < 8; k++) begin
      mult_s[k] = mult_s[k-1] + step_r;
    end
  end

  // Sub-bit phases relative to the pre-update counter; earliest sample goes to bit 7
  always_comb begin
    logic [BW-1:0] phase_s;
    word_s  = 8'h00;
    phase_s = '0;
    for (int k = 0; k < 8; k++) begin
      phase_s       = ctr_r + mult_r[k];
      word_s[7 - k] = phase_s[BW-1];
    end
  end

  // Step, multiples, phase counter and output word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      step_r <= '0;
      for (int k = 0; k < 8; k++) begin
        mult_r[k] <= '0;
      end
      ctr_r  <= '0;
      word_r <= 8'h00;
    end else begin
      if (bus.i_stb) begin
        step_r <= bus.i_delay;
      end
      mult_r <= mult_s;
      ctr_r  <= ctr_r + mult_r[7];
      word_r <= word_s;
    end
  end

  // Warm-up state and registered valid flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st_r  <= WARM0;
      stb_r <= 1'b0;
    end else begin
      st_r  <= st_s;
      stb_r <= stb_s;
    end
  end

  // Valid stays low until the three pipeline stages hold post-reset data
  always_comb begin
    st_s  = st_r;
    stb_s = 1'b0;
    case (st_r)
      WARM0: begin
        st_s  = WARM1;
        stb_s = 1'b0;
      end
      WARM1: begin
        st_s  = WARM2;
        stb_s = 1'b0;
      end
      WARM2: begin
        st_s  = RUN;
        stb_s = 1'b1;
      end
      RUN: begin
        st_s  = RUN;
        stb_s = 1'b1;
      end
      default: begin
        st_s  = WARM0;
        stb_s = 1'b0;
      end
    endcase
  end

  assign bus.o_word = word_r;
  assign bus.o_stb  = stb_r;

endmodule

// File: tb/tb_genclk.sv
// Self-checking bench for genclk: hand-derived vector table plus a modular
// phase-accumulator scoreboard over directed and random step sequences.
module tb_genclk;

  typedef struct {
    logic        rst;
    logic        stb;
    logic [31:0] delay;
    logic [7:0]  word;
    logic        ostb;
  } vec_t;

  typedef struct {
    logic [7:0] word;
    logic       ostb;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  genclk_if #(.BW(32)) bus ();

  genclk #(.BW(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pending step, step feeding the multiples, phase, and run length since reset
  logic [31:0] m_step;
  logic [31:0] m_mstep;
  logic [31:0] m_ctr;
  int          m_run;
  exp_t        exp_q[$];

  function automatic logic [7:0] ref_word(input logic [31:0] c, input logic [31:0] s);
    logic [7:0]  w;
    logic [31:0] p;
    w = 8'h00;
    for (int k = 0; k < 8; k++) begin
      p        = c + s * 32'(k + 1);
      w[7 - k] = p[31];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, push the model's prediction, clock, then compare
  task automatic cycle(input logic r, input logic s, input logic [31:0] d);
    exp_t e;
    rst         = r;
    bus.i_stb   = s;
    bus.i_delay = d;
    if (r) begin
      e.word  = 8'h00;
      e.ostb  = 1'b0;
      m_step  = 32'h0;
      m_mstep = 32'h0;
      m_ctr   = 32'h0;
      m_run   = 0;
    end else begin
      m_run   = m_run + 1;
      e.word  = ref_word(m_ctr, m_mstep);
      e.ostb  = (m_run >= 3);
      m_ctr   = m_ctr + m_mstep * 32'd8;
      m_mstep = m_step;
      if (s) begin
        m_step = d;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got 0 entries, expected 1");
    end else begin
      e = exp_q.pop_front();
      check("sb_word", {24'h0, bus.o_word}, {24'h0, e.word});
      check("sb_ostb", {31'h0, bus.o_stb}, {31'h0, e.ostb});
    end
  endtask

  vec_t vecs[$];

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.i_stb   = 1'b0;
    bus.i_delay = 32'h0;
    m_step      = 32'h0;
    m_mstep     = 32'h0;
    m_ctr       = 32'h0;
    m_run       = 0;

    // Step 0x20000000 loaded in the first post-reset cycle: 0x1E from R+3
    vecs.push_back('{1'b1, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h20000000, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h1E, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h1E, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h1E, 1'b1});
    // Step 0x10000000: alternating 0x01 / 0xFE
    vecs.push_back('{1'b1, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10000000, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'hFE, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'hFE, 1'b1});
    // Step 0x80000000: constant 0xAA
    vecs.push_back('{1'b1, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h80000000, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'hAA, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'hAA, 1'b1});
    // Strobe coincident with reset is lost: step stays 0, word stays 0x00
    vecs.push_back('{1'b1, 1'b1, 32'h20000000, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        8'h00, 1'b1});

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].stb, vecs[i].delay);
      check($sformatf("vec%0d_word", i), {24'h0, bus.o_word}, {24'h0, vecs[i].word});
      check($sformatf("vec%0d_ostb", i), {31'h0, bus.o_stb}, {31'h0, vecs[i].ostb});
    end

    // Reset mid-operation while running at 0x80000000
    cycle(1'b0, 1'b1, 32'h80000000);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("midrst_word", {24'h0, bus.o_word}, 32'h0);
    check("midrst_ostb", {31'h0, bus.o_stb}, 32'h0);

    // Running at 0x10000000, switch to 0x20000000 with the counter continuing
    cycle(1'b0, 1'b1, 32'h10000000);
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h20000000);
    repeat (8) cycle(1'b0, 1'b0, 32'h0);

    // Back-to-back strobes, each followed in order
    cycle(1'b0, 1'b1, 32'h12345678);
    cycle(1'b0, 1'b1, 32'hF0000001);
    cycle(1'b0, 1'b1, 32'h0BADBEEF);
    cycle(1'b0, 1'b1, 32'h9ABCDEF0);
    repeat (6) cycle(1'b0, 1'b0, 32'h0);

    // Random steps, strobes and occasional resets
    for (int n = 0; n < 20000; n++) begin
      cycle(($urandom_range(0, 999) == 0),
            ($urandom_range(0, 7) == 0),
            $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
